// File: rtl/onehot_mux_pkg.sv
// Shared constants, types and one-hot helpers for the one-hot arbitrating mux.
package onehot_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Widest channel vector the helpers accept; callers zero-extend into it.
    localparam int MAX_CH = 64;

    typedef logic [MAX_CH-1:0] ch_vec_t;
    typedef logic [7:0]        err_cnt_t;

    localparam err_cnt_t ERR_CNT_MAX = 8'hFF;

    function automatic logic is_onehot(input ch_vec_t v);
        return (v != '0) && ((v & (v - ch_vec_t'(1))) == '0);
    endfunction

    // True when two or more bits are set: clearing the lowest set bit leaves something.
    function automatic logic is_multihot(input ch_vec_t v);
        return (v & (v - ch_vec_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/onehot_arb_mux_if.sv
// Producer/consumer bundle of the one-hot arbitrating mux.
interface onehot_arb_mux_if
    import onehot_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) ();

    logic [NUM_CH-1:0]        req_i;
    logic [NUM_CH*DATA_W-1:0] data_i;
    logic [NUM_CH-1:0]        sel_i;
    logic [NUM_CH-1:0]        ack_o;
    logic                     valid_o;
    logic [DATA_W-1:0]        data_o;
    logic [NUM_CH-1:0]        gnt_o;
    logic                     ready_i;
    err_cnt_t                 err_cnt_o;

    modport master (
        output req_i, data_i, sel_i, ready_i,
        input  ack_o, valid_o, data_o, gnt_o, err_cnt_o
    );

    modport slave (
        input  req_i, data_i, sel_i, ready_i,
        output ack_o, valid_o, data_o, gnt_o, err_cnt_o
    );

endinterface

// File: rtl/onehot_rr_arb.sv
// Combinational round-robin arbiter: first request at or above the one-hot pointer, with wrap.
module onehot_rr_arb #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] ptr,
    output logic [NUM_CH-1:0] gnt
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] gnt_dbl;

    assign req_dbl = {req, req};

    // Subtracting the pointer borrows up to the first request at or above it;
    // doubling the vector makes the search wrap past the top channel.
    assign gnt_dbl = req_dbl & ~(req_dbl - {{NUM_CH{1'b0}}, ptr});

    assign gnt = gnt_dbl[NUM_CH-1:0] | gnt_dbl[2*NUM_CH-1:NUM_CH];

endmodule

// File: rtl/onehot_arb_mux.sv
// N-channel one-hot mux with external-select or round-robin grant and a registered valid/ready stage.
module onehot_arb_mux
    import onehot_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int MODE   = MODE_SEL
) (
    input  logic               clk,
    input  logic               reset_n,
    onehot_arb_mux_if.slave    bus
);

    logic [NUM_CH-1:0] ptr_q;
    logic [NUM_CH-1:0] ptr_next;
    logic [NUM_CH-1:0] rr_gnt;
    logic [NUM_CH-1:0] grant;
    logic              load;
    logic              sel_hit;
    logic              sel_illegal;

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [NUM_CH-1:0] gnt_q;
    err_cnt_t          err_q;
    logic [DATA_W-1:0] mux_data;

    assign load        = !valid_q || bus.ready_i;
    assign sel_illegal = is_multihot(ch_vec_t'(bus.sel_i));
    assign sel_hit     = is_onehot(ch_vec_t'(bus.sel_i)) && ((bus.req_i & bus.sel_i) != '0);

    onehot_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_rr_arb (
        .req (bus.req_i),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant = '0;
        // Gating with reset_n keeps ack_o silent while reset is held, even though load is 1 then.
        if (reset_n && load) begin
            if (MODE == MODE_RR) begin
                grant = rr_gnt;
            end else if (sel_hit) begin
                grant = bus.sel_i;
            end
        end
    end

    // AND-OR select: each channel contributes only when its grant bit is set.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            mux_data = mux_data | (bus.data_i[k*DATA_W +: DATA_W] & {DATA_W{grant[k]}});
        end
    end

    // Rotate left by one; for a single channel this folds back onto bit 0.
    assign ptr_next = (grant << 1) | (grant >> (NUM_CH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            valid_q <= 1'b0;
            gnt_q   <= '0;
            // NOTE: the data register is reset too, so a reset visibly clears the held word.
            data_q  <= '0;
        end else if (load) begin
            if (grant != '0) begin
                valid_q <= 1'b1;
                gnt_q   <= grant;
                data_q  <= mux_data;
            end else begin
                valid_q <= 1'b0;
                gnt_q   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= NUM_CH'(1);
        end else if (MODE == MODE_RR && grant != '0) begin
            ptr_q <= ptr_next;
        end
    end

    // Illegal selects are counted once per load cycle, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (MODE == MODE_SEL && load && sel_illegal && err_q != ERR_CNT_MAX) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.ack_o     = grant;
    assign bus.valid_o   = valid_q;
    assign bus.data_o    = data_q;
    assign bus.gnt_o     = gnt_q;
    assign bus.err_cnt_o = err_q;

endmodule

// File: tb/tb_onehot_arb_mux.sv
// Directed bench for onehot_arb_mux: one select-mode and one round-robin instance on a shared clock/reset.
module tb_onehot_arb_mux;
    import onehot_mux_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam logic [NUM_CH*DATA_W-1:0] CH_DATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    onehot_arb_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) sif ();
    onehot_arb_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) rif ();

    onehot_arb_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MODE(MODE_SEL)) u_sel (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sif)
    );

    onehot_arb_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .MODE(MODE_RR)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (rif)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] sel_seq  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] sel_dat  [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [3:0] rr_seq   [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [7:0] rr_dat   [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1};

    initial begin
        reset_n     = 1'b0;
        sif.req_i   = '0;
        sif.data_i  = CH_DATA;
        sif.sel_i   = '0;
        sif.ready_i = 1'b0;
        rif.req_i   = 4'b1111;
        rif.data_i  = CH_DATA;
        rif.sel_i   = '0;
        rif.ready_i = 1'b0;

        // Reset state, and no accept while reset is held even with requests pending.
        #12;
        chk("rst_sel_valid", 32'(sif.valid_o),   32'(0));
        chk("rst_sel_gnt",   32'(sif.gnt_o),     32'(0));
        chk("rst_sel_data",  32'(sif.data_o),    32'(0));
        chk("rst_sel_err",   32'(sif.err_cnt_o), 32'(0));
        chk("rst_rr_valid",  32'(rif.valid_o),   32'(0));
        chk("rst_rr_ack",    32'(rif.ack_o),     32'(0));

        @(negedge clk);
        reset_n     = 1'b1;
        rif.req_i   = '0;
        sif.req_i   = 4'b1111;
        sif.ready_i = 1'b1;

        // Select mode: one word per cycle following sel_i.
        for (int i = 0; i < 4; i++) begin
            sif.sel_i = sel_seq[i];
            #1;
            chk("sel_ack", 32'(sif.ack_o), 32'(sel_seq[i]));
            tick();
            chk("sel_valid", 32'(sif.valid_o), 32'(1));
            chk("sel_data",  32'(sif.data_o),  32'(sel_dat[i]));
            chk("sel_gnt",   32'(sif.gnt_o),   32'(sel_seq[i]));
        end

        // Empty select: no grant, output drains, data holds.
        sif.sel_i = 4'b0000;
        #1;
        chk("sel0_ack", 32'(sif.ack_o), 32'(0));
        tick();
        chk("sel0_valid", 32'(sif.valid_o),   32'(0));
        chk("sel0_gnt",   32'(sif.gnt_o),     32'(0));
        chk("sel0_data",  32'(sif.data_o),    32'(8'hA3));
        chk("sel0_err",   32'(sif.err_cnt_o), 32'(0));

        // Multi-hot select for three load cycles.
        sif.sel_i = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("multi_ack", 32'(sif.ack_o), 32'(0));
            tick();
            chk("multi_valid", 32'(sif.valid_o), 32'(0));
        end
        chk("multi_err3", 32'(sif.err_cnt_o), 32'(3));
        sif.sel_i = 4'b0000;
        sif.req_i = 4'b0000;

        // Round-robin with all channels requesting.
        rif.req_i   = 4'b1111;
        rif.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_ack", 32'(rif.ack_o), 32'(rr_seq[i]));
            tick();
            chk("rr_gnt",  32'(rif.gnt_o),  32'(rr_seq[i]));
            chk("rr_data", 32'(rif.data_o), 32'(rr_dat[i]));
        end

        rif.req_i = 4'b1000;
        #1;
        chk("rr_hi_ack", 32'(rif.ack_o), 32'(4'b1000));
        tick();
        chk("rr_hi_gnt",  32'(rif.gnt_o),  32'(4'b1000));
        chk("rr_hi_data", 32'(rif.data_o), 32'(8'hA3));

        rif.req_i = 4'b0011;
        #1;
        chk("rr_wrap_ack", 32'(rif.ack_o), 32'(4'b0001));
        tick();
        chk("rr_wrap_gnt",  32'(rif.gnt_o),  32'(4'b0001));
        chk("rr_wrap_data", 32'(rif.data_o), 32'(8'hA0));

        // Backpressure: output frozen, no accept, pointer must not move.
        rif.ready_i = 1'b0;
        rif.req_i   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_ack", 32'(rif.ack_o), 32'(0));
            tick();
            chk("bp_valid", 32'(rif.valid_o), 32'(1));
            chk("bp_gnt",   32'(rif.gnt_o),   32'(4'b0001));
            chk("bp_data",  32'(rif.data_o),  32'(8'hA0));
        end
        rif.ready_i = 1'b1;
        #1;
        chk("bp_resume_ack", 32'(rif.ack_o), 32'(4'b0010));
        tick();
        chk("bp_resume_gnt",  32'(rif.gnt_o),  32'(4'b0010));
        chk("bp_resume_data", 32'(rif.data_o), 32'(8'hA1));

        // Asynchronous reset mid-stream, away from any clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_rr_valid", 32'(rif.valid_o),   32'(0));
        chk("arst_rr_gnt",   32'(rif.gnt_o),     32'(0));
        chk("arst_rr_data",  32'(rif.data_o),    32'(0));
        chk("arst_rr_ack",   32'(rif.ack_o),     32'(0));
        chk("arst_sel_err",  32'(sif.err_cnt_o), 32'(0));
        chk("arst_sel_data", 32'(sif.data_o),    32'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_ack", 32'(rif.ack_o), 32'(4'b0001));
        tick();
        chk("post_rst_gnt", 32'(rif.gnt_o), 32'(4'b0001));

        // Error counter saturation under a persistent all-ones select.
        sif.req_i = 4'b1111;
        sif.sel_i = 4'b1111;
        repeat (254) tick();
        chk("sat_254", 32'(sif.err_cnt_o), 32'(254));
        chk("sat_ack", 32'(sif.ack_o),     32'(0));
        tick();
        chk("sat_255", 32'(sif.err_cnt_o), 32'(255));
        repeat (45) tick();
        chk("sat_hold",  32'(sif.err_cnt_o), 32'(255));
        chk("sat_valid", 32'(sif.valid_o),   32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
